// File: rtl/otter_dmem_port_if.sv
// Bundle for the OTTER data-memory port.
// It carries the MEM-stage load/store request, the load result and the IO bus.
interface otter_dmem_port_if;
  logic [31:0] MEM_ADDR2;
  logic [31:0] MEM_DIN2;
  logic        MEM_WRITE2;
  logic        MEM_READ2;
  logic [1:0]  MEM_SIZE;
  logic        MEM_UNSIGNED;
  logic [31:0] MEM_DOUT2;
  logic        ERR;
  logic        BUSY;
  logic [31:0] IO_IN;
  logic [31:0] IO_ADDR;
  logic [31:0] IO_DOUT;
  logic        IO_WR;

  // The master is the pipeline together with the IO devices.
  modport master (
    output MEM_ADDR2, MEM_DIN2, MEM_WRITE2, MEM_READ2, MEM_SIZE, MEM_UNSIGNED, IO_IN,
    input  MEM_DOUT2, ERR, BUSY, IO_ADDR, IO_DOUT, IO_WR
  );

  modport slave (
    input  MEM_ADDR2, MEM_DIN2, MEM_WRITE2, MEM_READ2, MEM_SIZE, MEM_UNSIGNED, IO_IN,
    output MEM_DOUT2, ERR, BUSY, IO_ADDR, IO_DOUT, IO_WR
  );
endinterface

// File: rtl/otter_dmem_port.sv
// OTTER data-side memory responder: word RAM with byte lanes plus an IO window.
// The IO window is serviced through a wait-state FSM that stalls the pipeline.
module otter_dmem_port #(
  parameter int          DEPTH_WORDS = 16384,
  parameter logic [31:0] IO_BASE     = 32'h1100_0000,
  parameter int          IO_WAIT     = 2
) (
  input logic               CLK,
  input logic               RST,
  otter_dmem_port_if.slave  bus
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [29:0] LP_DEPTH = 30'(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  function automatic logic [31:0] f_replicate(input logic [31:0] din, input logic [1:0] size);
    case (size)
      2'b00:   return {4{din[7:0]}};
      2'b01:   return {2{din[15:0]}};
      default: return din;
    endcase
  endfunction

  function automatic logic [3:0] f_byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] f_load_ext(input logic [31:0] word, input logic [1:0] off,
                                             input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_err;
  logic        r_io_wr;
  logic [31:0] r_io_addr;
  logic [31:0] r_io_dout;
  logic        r_io_is_wr;
  logic [1:0]  r_io_off;
  logic [1:0]  r_io_size;
  logic        r_io_uns;
  logic [31:0] r_io_word;
  logic        r_ld_zero;
  logic        r_ld_io;
  logic [1:0]  r_ld_off;
  logic [1:0]  r_ld_size;
  logic        r_ld_uns;
  logic [31:0] r_ram_q;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_req;
  logic          w_is_io;
  logic          w_range_err;
  logic          w_illegal;
  logic          w_accept;
  logic          w_ram_wr;
  logic          w_ram_rd;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_ld_word;

  assign w_req       = bus.MEM_READ2 | bus.MEM_WRITE2;
  assign w_is_io     = bus.MEM_ADDR2 >= IO_BASE;
  // Out-of-range RAM indices are rejected rather than aliased onto low memory.
  assign w_range_err = !w_is_io && (bus.MEM_ADDR2[31:2] >= LP_DEPTH);
  assign w_illegal   = (bus.MEM_READ2 & bus.MEM_WRITE2)
                     | (bus.MEM_SIZE == 2'b11)
                     | ((bus.MEM_SIZE == 2'b01) & bus.MEM_ADDR2[0])
                     | ((bus.MEM_SIZE == 2'b10) & (bus.MEM_ADDR2[1:0] != 2'b00))
                     | w_range_err;
  assign w_accept    = (r_state == S_IDLE) && w_req && !RST;
  assign w_ram_wr    = w_accept && !w_illegal && !w_is_io && bus.MEM_WRITE2;
  assign w_ram_rd    = w_accept && !w_illegal && !w_is_io && bus.MEM_READ2;
  assign w_idx       = bus.MEM_ADDR2[AW+1:2];
  assign w_be        = f_byte_en(bus.MEM_SIZE, bus.MEM_ADDR2[1:0]);
  assign w_wdata     = f_replicate(bus.MEM_DIN2, bus.MEM_SIZE);

  // RAM array and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge CLK) begin
    if (w_ram_wr) begin
      for (int l = 0; l < 4; l++) begin
        if (w_be[l]) r_mem[w_idx][8*l +: 8] <= w_wdata[8*l +: 8];
      end
    end
    if (w_ram_rd) r_ram_q <= r_mem[w_idx];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_err      <= 1'b0;
      r_io_wr    <= 1'b0;
      r_io_addr  <= 32'h0;
      r_io_dout  <= 32'h0;
      r_io_is_wr <= 1'b0;
      r_io_off   <= 2'b00;
      r_io_size  <= 2'b00;
      r_io_uns   <= 1'b0;
      r_io_word  <= 32'h0;
      r_ld_zero  <= 1'b1;
      r_ld_io    <= 1'b0;
      r_ld_off   <= 2'b00;
      r_ld_size  <= 2'b00;
      r_ld_uns   <= 1'b0;
    end else begin
      r_err <= w_accept && w_illegal;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_illegal) begin
              r_ld_zero <= 1'b1;
            end else if (w_is_io) begin
              r_io_addr  <= bus.MEM_ADDR2;
              r_io_dout  <= w_wdata;
              r_io_is_wr <= bus.MEM_WRITE2;
              r_io_off   <= bus.MEM_ADDR2[1:0];
              r_io_size  <= bus.MEM_SIZE;
              r_io_uns   <= bus.MEM_UNSIGNED;
              if (IO_WAIT == 0) begin
                r_state <= S_RESP;
                r_io_wr <= bus.MEM_WRITE2;
              end else begin
                r_state <= S_WAIT;
                r_cnt   <= 4'(IO_WAIT);
              end
            end else if (bus.MEM_READ2) begin
              r_ld_zero <= 1'b0;
              r_ld_io   <= 1'b0;
              r_ld_off  <= bus.MEM_ADDR2[1:0];
              r_ld_size <= bus.MEM_SIZE;
              r_ld_uns  <= bus.MEM_UNSIGNED;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_RESP;
            r_io_wr <= r_io_is_wr;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_io_wr <= 1'b0;
          if (!r_io_is_wr) begin
            r_io_word <= bus.IO_IN;
            r_ld_zero <= 1'b0;
            r_ld_io   <= 1'b1;
            r_ld_off  <= r_io_off;
            r_ld_size <= r_io_size;
            r_ld_uns  <= r_io_uns;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Extension happens after the load register; r_ld_zero blanks it on reset and on errors.
  assign w_ld_word     = r_ld_io ? r_io_word : r_ram_q;
  assign bus.MEM_DOUT2 = r_ld_zero ? 32'h0 : f_load_ext(w_ld_word, r_ld_off, r_ld_size, r_ld_uns);
  assign bus.ERR       = r_err;
  assign bus.BUSY      = ((r_state == S_IDLE) && w_req && !w_illegal && w_is_io) || (r_state == S_WAIT);
  assign bus.IO_ADDR   = r_io_addr;
  assign bus.IO_DOUT   = r_io_dout;
  assign bus.IO_WR     = r_io_wr;

endmodule
